// File: rtl/ascii_response_encoder.sv
// ascii_response_encoder: serialises a register read/error report as an ASCII line
// ("read aa dddddddd\n" or "err aa\n") onto a byte stream with valid/ready flow control.
module ascii_response_encoder #(
    parameter bit UPPERCASE_HEX = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_data,
    input  logic        req_err,
    output logic        m_tvalid,
    output logic [7:0]  m_tdata,
    input  logic        m_tready,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, PREFIX, ADDR, SEP, DATA, EOL} state_t;

    state_t      state, state_nxt, adv;
    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  addr_q, addr_src;
    logic [31:0] data_q, data_src;
    logic        err_q, err_src;
    logic        hs, accept, last;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : (UPPERCASE_HEX ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    // Character emitted while sitting in state s at index i of the frame segment
    function automatic logic [7:0] char_at(input state_t s, input logic [3:0] i,
                                           input logic [7:0] a, input logic [31:0] d,
                                           input logic e);
        case (s)
            PREFIX:  return 8'((e ? 40'h6572722000 : 40'h7265616420) >> (7'd32 - {i, 3'b000}));
            ADDR:    return hex(i[0] ? a[3:0] : a[7:4]);
            SEP:     return 8'h20;
            DATA:    return hex(4'(d >> {4'd7 - i, 2'b00}));
            EOL:     return 8'h0a;
            default: return 8'h00;
        endcase
    endfunction

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign hs        = m_tvalid & m_tready;
    assign accept    = req_valid & req_ready;
    assign addr_src  = accept ? req_addr : addr_q;
    assign data_src  = accept ? req_data : data_q;
    assign err_src   = accept ? req_err : err_q;

    always_comb begin
        last = state == PREFIX ? cnt == (err_q ? 4'd3 : 4'd4) :
               state == ADDR   ? cnt == 4'd1 :
               state == DATA   ? cnt == 4'd7 : 1'b1;
        case (state)
            IDLE:    adv = PREFIX;
            PREFIX:  adv = ADDR;
            ADDR:    adv = err_q ? EOL : SEP;
            SEP:     adv = DATA;
            DATA:    adv = EOL;
            default: adv = IDLE;
        endcase
        state_nxt = state == IDLE ? (req_valid ? PREFIX : IDLE) : (hs && last ? adv : state);
        cnt_nxt   = hs ? (last ? 4'd0 : cnt + 4'd1) : cnt;
    end

    // The next byte is computed from the next state so m_tdata is a plain register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            m_tvalid <= 1'b0;
            m_tdata  <= 8'h00;
            addr_q   <= 8'h00;
            data_q   <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            m_tvalid <= state_nxt != IDLE;
            m_tdata  <= char_at(state_nxt, cnt_nxt, addr_src, data_src, err_src);
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_data;
                err_q  <= req_err;
            end
        end
    end
endmodule

// File: tb/tb_ascii_response_encoder.sv
// tb_ascii_response_encoder: random and directed frames on lower- and upper-case encoders,
// checked byte by byte against a string-built reference frame.
module tb_ascii_response_encoder;
    logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, m_tready = 1'b1;
    logic [7:0]  req_addr = 8'h0;
    logic [31:0] req_data = 32'h0;
    logic        req_err = 1'b0;
    logic        req_ready0, m_tvalid0, busy0, req_ready1, m_tvalid1, busy1;
    logic [7:0]  m_tdata0, m_tdata1;

    int n_chk = 0, n_fail = 0, cyc = 0, mode = 0, nb = 0, vcyc = 0, cur_len = 0, eol_cyc = 0;
    byte q0[$], q1[$];
    string ov0 = "", ov1 = "";
    logic stall_prev = 0, acc_prev = 0, pv = 0;
    logic [7:0] prev0, prev1;

    ascii_response_encoder #(.UPPERCASE_HEX(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
        .req_addr(req_addr), .req_data(req_data), .req_err(req_err),
        .m_tvalid(m_tvalid0), .m_tdata(m_tdata0), .m_tready(m_tready), .busy(busy0));
    ascii_response_encoder #(.UPPERCASE_HEX(1'b1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
        .req_addr(req_addr), .req_data(req_data), .req_err(req_err),
        .m_tvalid(m_tvalid1), .m_tdata(m_tdata1), .m_tready(m_tready), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic string frame(input logic [7:0] a, input logic [31:0] d,
                                    input logic e, input bit up);
        string hx, s;
        if (up) hx = "0123456789ABCDEF"; else hx = "0123456789abcdef";
        if (e) s = "err "; else s = "read ";
        for (int i = 1; i >= 0; i--) s = {s, hx.substr(int'(a[4*i+:4]), int'(a[4*i+:4]))};
        if (!e) begin
            s = {s, " "};
            for (int i = 7; i >= 0; i--) s = {s, hx.substr(int'(d[4*i+:4]), int'(d[4*i+:4]))};
        end
        return {s, "\n"};
    endfunction

    // Sink ready pattern: 0 always ready, 1 toggling starting ready on each frame, 2 random
    always @(negedge clk) pv = m_tvalid0;
    always @(posedge clk) begin
        #1;
        m_tready = mode == 0 ? 1'b1 : mode == 1 ? (!pv ? 1'b1 : !m_tready) : 1'($urandom);
    end

    always @(negedge clk) begin
        if (reset) begin
            q0.delete(); q1.delete();
            nb = 0; vcyc = 0; stall_prev = 0; acc_prev = 0;
        end else begin
            chk("busy_eq_valid", busy0, m_tvalid0);
            chk("ready_eq_idle", req_ready0, !busy0);
            chk("valid_match", m_tvalid1, m_tvalid0);
            if (acc_prev) chk("valid_after_accept", m_tvalid0, 1'b1);
            if (stall_prev) begin
                chk("stall_hold0", m_tdata0, prev0);
                chk("stall_hold1", m_tdata1, prev1);
            end
            if (m_tvalid0) vcyc++;
            if (m_tvalid0 && m_tready) begin
                chk("byte0", m_tdata0, q0.size() > 0 ? q0.pop_front() : 8'hff);
                chk("byte1", m_tdata1, q1.size() > 0 ? q1.pop_front() : 8'hff);
                nb++;
                if (m_tdata0 == 8'h0a) begin
                    if (mode == 0) chk("frame_len", vcyc, cur_len);
                    if (mode == 1) chk("frame_len_toggle", vcyc, 2 * cur_len - 1);
                    eol_cyc = cyc; vcyc = 0; nb = 0;
                end
            end
            stall_prev = m_tvalid0 && !m_tready;
            prev0 = m_tdata0; prev1 = m_tdata1;
            acc_prev = req_valid && req_ready0;
            if (acc_prev) begin
                string s0, s1;
                s0 = ov0.len() > 0 ? ov0 : frame(req_addr, req_data, req_err, 0);
                s1 = ov1.len() > 0 ? ov1 : frame(req_addr, req_data, req_err, 1);
                ov0 = ""; ov1 = "";
                for (int i = 0; i < s0.len(); i++) q0.push_back(s0[i]);
                for (int i = 0; i < s1.len(); i++) q1.push_back(s1[i]);
                cur_len = s0.len(); vcyc = 0; nb = 0;
            end
        end
    end

    // Called at posedge+1; returns the cycle whose closing edge accepts the request
    task automatic send(input logic [7:0] a, input logic [31:0] d, input logic e,
                        input bit hold, output int acc);
        bit ok = 0;
        req_addr = a; req_data = d; req_err = e; req_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready0;
        end
        chk("accept_timeout", ok, 1'b1);
        acc = cyc;
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_addr = 8'($urandom); req_data = $urandom; req_err = 1'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            #1;
            done = !busy0 && q0.size() == 0;
        end
        chk("drain_timeout", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t1, t2;
        #3;
        chk("rst_valid", m_tvalid0, 1'b0);
        chk("rst_data", m_tdata0, 8'h00);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_ready", req_ready0, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        ov0 = "read 3c deadbeef\n";
        send(8'h3c, 32'hdeadbeef, 1'b0, 0, t1);
        wait_idle();

        mode = 1;
        ov0 = "read 3c deadbeef\n";
        send(8'h3c, 32'hdeadbeef, 1'b0, 0, t1);
        wait_idle();
        mode = 0;

        ov0 = "err 07\n"; ov1 = "err 07\n";
        send(8'h07, 32'hffffffff, 1'b1, 0, t1);
        wait_idle();

        ov0 = "read 01 00000000\n";
        send(8'h01, 32'h0, 1'b0, 1, t1);
        ov0 = "read 02 12345678\n";
        send(8'h02, 32'h12345678, 1'b0, 0, t2);
        chk("b2b_after_eol", t2, eol_cyc + 1);
        chk("b2b_spacing", t2 - t1, 18);
        wait_idle();

        ov1 = "read AB 00C0FFEE\n";
        send(8'hab, 32'h00c0ffee, 1'b0, 0, t1);
        wait_idle();

        send(8'h55, 32'hcafef00d, 1'b0, 0, t1);
        for (int k = 0; k < 50 && nb < 6; k++) begin
            @(negedge clk);
            #1;
        end
        chk("reach_byte6", nb, 6);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_valid", m_tvalid0, 1'b0);
        chk("abort_valid1", m_tvalid1, 1'b0);
        chk("abort_data", m_tdata0, 8'h00);
        chk("abort_busy", busy0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_abort_idle", m_tvalid0, 1'b0);
        ov0 = "read 10 00000001\n";
        send(8'h10, 32'h1, 1'b0, 0, t1);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            bit hold;
            hold = k < 39 && $urandom_range(0, 2) == 0;
            send(8'($urandom), $urandom, $urandom_range(0, 3) == 0, hold, t1);
            if (!hold) begin
                wait_idle();
                mode = $urandom_range(0, 2);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ascii_response_encoder.md
ASCII_RESPONSE_ENCODER -- requirements
Module: ascii_response_encoder

Interface
REQ-001 Parameter: UPPERCASE_HEX, default 0, 1 = hex digits a-f emitted as "A"-"F", 0 = "a"-"f".
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  response request present.
REQ-005 req_ready  output  1  encoder idle, request accepted this cycle if req_valid.
REQ-006 req_addr  input  8  register address being reported.
REQ-007 req_data  input  32  read data being reported.
REQ-008 req_err  input  1  1 = report error frame instead of data frame.
REQ-009 m_tvalid  output  1  output byte valid.
REQ-010 m_tdata  output  8  ASCII output byte.
REQ-011 m_tready  input  1  downstream sink accepts byte.
REQ-012 busy  output  1  frame in progress (high from acceptance to final byte handshake).

Function
REQ-013 Request handshake SHALL occur in any cycle with req_valid=1 and req_ready=1; req_addr, req_data, req_err SHALL be captured into internal registers on that edge.
REQ-014 req_ready SHALL be 1 only in state IDLE; input changes after acceptance SHALL NOT affect the frame in flight.
REQ-015 Data frame (req_err=0), 17 bytes in order: "r","e","a","d"," ", addr hex hi nibble, addr hex lo nibble, " ", data nibbles [31:28] down to [3:0] (8 chars), 0x0A.
REQ-016 Error frame (req_err=1), 7 bytes in order: "e","r","r"," ", addr hi nibble, addr lo nibble, 0x0A.
REQ-017 Nibble to ASCII: 0-9 -> 0x30-0x39; 10-15 -> 0x61-0x66 (UPPERCASE_HEX=0) or 0x41-0x46 (UPPERCASE_HEX=1).
REQ-018 States: IDLE, PREFIX, ADDR, SEP, DATA, EOL; byte index counter (4 bits) selects character within PREFIX/ADDR/DATA.
REQ-019 Transitions: IDLE->PREFIX on request handshake; PREFIX->ADDR after last prefix byte ("read " 5 bytes, "err " 4 bytes); ADDR->SEP (data frame) or ADDR->EOL (error frame) after 2 bytes; SEP->DATA after 1 byte; DATA->EOL after 8 bytes; EOL->IDLE after 0x0A handshake.
REQ-020 Every state transition and counter advance SHALL occur only on a byte handshake (m_tvalid=1 and m_tready=1).
REQ-021 m_tvalid SHALL assert the cycle after request acceptance and stay 1 through every non-IDLE state; 0 in IDLE.
REQ-022 While m_tvalid=1 and m_tready=0, m_tdata SHALL hold stable.
REQ-023 m_tdata SHALL be registered (no combinational path from m_tready or req_* to m_tdata/m_tvalid).
REQ-024 With m_tready held 1: data frame occupies 17 consecutive cycles, error frame 7; req_ready returns to 1 the cycle after the 0x0A handshake (minimum 18-cycle request-to-request spacing for data frames).
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 m_tready asserted while m_tvalid=0 SHALL have no effect.

Reset
REQ-027 reset=1 SHALL immediately force: state IDLE, counter 0, m_tvalid 0, m_tdata 0x00, busy 0, req_ready 1 after release, captured registers 0.
REQ-028 Reset mid-frame SHALL abort the frame; no remaining bytes emitted after release; next request starts a fresh frame at its first byte.

Verification
REQ-029 addr=0x3C, data=0xDEADBEEF, err=0, m_tready=1, UPPERCASE_HEX=0 -> bytes "read 3c deadbeef\n" (72 65 61 64 20 33 63 20 64 65 61 64 62 65 65 66 0A) on 17 consecutive cycles starting cycle after acceptance.
REQ-030 Same request, m_tready toggled 1/0 each cycle -> identical byte sequence, m_tdata stable during every stall, frame takes 33 cycles.
REQ-031 addr=0x07, err=1 (data=0xFFFFFFFF ignored) -> "err 07\n" (65 72 72 20 30 37 0A), 7 bytes.
REQ-032 req_valid held 1 with two back-to-back requests (0x01/0x00000000, then 0x02/0x12345678) -> second accepted only the cycle after first frame's 0x0A handshake; req_ready=0 throughout first frame; both frames intact.
REQ-033 UPPERCASE_HEX=1, addr=0xAB, data=0x00C0FFEE -> "read AB 00C0FFEE\n".
REQ-034 reset asserted after 6th byte of a data frame -> m_tvalid falls asynchronously, no further bytes; after release, new request 0x10/0x00000001 yields complete "read 10 00000001\n".
